multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 91 +++++++++
 rtl/multicycle_ctrl_mem_wait_counter.sv | 32 +++
 rtl/multicycle_ctrl.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : multicycle_ctrl_pkg
// Brief  : Shared definitions for the multicycle controller: state codes,
//          opcode/funct constants, mux-select and ALU-op encodings.
// Rev    : 1.0  initial release
// ============================================================================
package multicycle_ctrl_pkg;

  // RESET is code 0 so that a zero-initialised register powers up in RESET.
  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_SP_INIT_WB = 5'd1,
    S_FETCH      = 5'd2,
    S_FETCH_WAIT = 5'd3,
    S_DECODE     = 5'd4,
    S_EXEC_R     = 5'd5,
    S_WB_R       = 5'd6,
    S_EXEC_I     = 5'd7,
    S_WB_I       = 5'd8,
    S_MEM_ADDR   = 5'd9,
    S_LOAD_REQ   = 5'd10,
    S_LOAD_WAIT  = 5'd11,
    S_LOAD_WB    = 5'd12,
    S_STORE      = 5'd13,
    S_BRANCH     = 5'd14,
    S_JUMP       = 5'd15,
    S_EXC_REQ    = 5'd16,
    S_EXC_WAIT   = 5'd17,
    S_EXC_JUMP   = 5'd18
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  // IorD
  localparam logic [1:0] IORD_PC     = 2'd0;
  localparam logic [1:0] IORD_ALUOUT = 2'd1;
  localparam logic [1:0] IORD_ILLEG  = 2'd2;  // vector address 253
  localparam logic [1:0] IORD_OVF    = 2'd3;  // vector address 254

  // RegDst
  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_SP = 2'd2;

  // MemToReg
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_SPINIT = 2'd2;

  // ALUSourceA
  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_A  = 1'b1;

  // ALUSourceB
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMMSH2 = 2'd3;

  // PCSource
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_MDR    = 2'd3;

  // AluOp
  localparam logic [2:0] ALU_PASSA = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;

  // States during which the memory wait counter runs.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH_WAIT) || (s == S_LOAD_WAIT) || (s == S_EXC_WAIT);
  endfunction

endpackage : multicycle_ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_ctrl_mem_wait_counter.sv
`default_nettype none
// ============================================================================
// Module : mem_wait_counter
// Brief  : 3-bit memory wait counter. Cleared while load is high; otherwise
//          counts up and saturates at MEM_WAIT-1, where done is raised.
// Ports  : clk, reset (sync, active-high), load (clear), done, count[2:0]
// Rev    : 1.0  initial release
// ============================================================================
module mem_wait_counter #(
  parameter int MEM_WAIT = 1   // legal range 1..7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  output logic       done,
  output logic [2:0] count
);

  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  assign done = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= 3'd0;
    end else if (!done) begin
      count <= count + 3'd1;
    end
  end

endmodule : mem_wait_counter
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module : multicycle_ctrl
// Brief  : Moore FSM controller for a multicycle MIPS-like datapath with
//          memory wait states and illegal-opcode / overflow exceptions.
// Ports  : clk, reset (sync, active-high); overflow, zero ALU flags;
//          opcode, funct IR fields; register/memory strobes; IorD, RegDst,
//          MemToReg, ALUSourceA/B, PCSource, AluOp mux selects;
//          reset_out (high in RESET), state_dbg (current state code).
// Rev    : 1.0  initial release
// ============================================================================
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_WAIT   = 1,    // 1..7 wait cycles after each memory read
  parameter bit OVF_EXC_EN = 1'b1,
  parameter int SP_INIT    = 227   // consumed by the datapath via MemToReg=2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       overflow,
  input  logic       zero,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       PC_write,
  output logic       PC_write_cond_eq,
  output logic       PC_write_cond_ne,
  output logic       MEMRead,
  output logic       MEMWrite,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       RegWrite,
  output logic       A_write,
  output logic       B_write,
  output logic       AluOutWrite,
  output logic       EPCWrite,
  output logic [1:0] IorD,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       ALUSourceA,
  output logic [1:0] ALUSourceB,
  output logic [1:0] PCSource,
  output logic [2:0] AluOp,
  output logic       reset_out,
  output logic [4:0] state_dbg
);

  state_t     state, next_state;
  logic [1:0] exc_sel, exc_sel_d;   // vector select latched on exception entry
  logic       wait_done;
  logic [2:0] wait_count;
  logic       ovf_trap_r, ovf_trap_i;
  logic       r_supported;

  // zero is consumed by the datapath, which qualifies the branch strobes.
  logic zero_unused;
  assign zero_unused = zero;

  // Clearing whenever the FSM is outside a wait state guarantees a fresh count
  // on every entry, including re-entry after a reset.
  mem_wait_counter #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .load  (!is_wait_state(state)),
    .done  (wait_done),
    .count (wait_count)
  );

  assign r_supported = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
  // AND never overflows, so only add/sub may trap.
  assign ovf_trap_r  = OVF_EXC_EN && overflow && ((funct == FN_ADD) || (funct == FN_SUB));
  assign ovf_trap_i  = OVF_EXC_EN && overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RESET;
      exc_sel <= IORD_PC;
    end else begin
      state   <= next_state;
      exc_sel <= exc_sel_d;
    end
  end

  assign state_dbg = state;

  always_comb begin
    next_state       = state;
    exc_sel_d        = exc_sel;
    PC_write         = 1'b0;
    PC_write_cond_eq = 1'b0;
    PC_write_cond_ne = 1'b0;
    MEMRead          = 1'b0;
    MEMWrite         = 1'b0;
    IRWrite          = 1'b0;
    MDRWrite         = 1'b0;
    RegWrite         = 1'b0;
    A_write          = 1'b0;
    B_write          = 1'b0;
    AluOutWrite      = 1'b0;
    EPCWrite         = 1'b0;
    IorD             = IORD_PC;
    RegDst           = RDST_RT;
    MemToReg         = M2R_ALUOUT;
    ALUSourceA       = SRCA_PC;
    ALUSourceB       = SRCB_B;
    PCSource         = PCS_ALU;
    AluOp            = ALU_PASSA;
    reset_out        = 1'b0;

    unique case (state)
      S_RESET: begin
        reset_out  = 1'b1;
        next_state = S_SP_INIT_WB;
      end

      S_SP_INIT_WB: begin
        RegWrite   = 1'b1;
        RegDst     = RDST_SP;
        MemToReg   = M2R_SPINIT;
        next_state = S_FETCH;
      end

      S_FETCH: begin
        MEMRead    = 1'b1;
        IorD       = IORD_PC;
        ALUSourceA = SRCA_PC;
        ALUSourceB = SRCB_FOUR;
        AluOp      = ALU_ADD;
        PC_write   = 1'b1;
        next_state = S_FETCH_WAIT;
      end

      S_FETCH_WAIT: begin
        if (wait_done) begin
          IRWrite    = 1'b1;
          next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        A_write     = 1'b1;
        B_write     = 1'b1;
        ALUSourceA  = SRCA_PC;
        ALUSourceB  = SRCB_IMMSH2;
        AluOp       = ALU_ADD;
        AluOutWrite = 1'b1;
        unique case (opcode)
          OP_RTYPE: begin
            if (r_supported) begin
              next_state = S_EXEC_R;
            end else begin
              next_state = S_EXC_REQ;
              exc_sel_d  = IORD_ILLEG;
            end
          end
          OP_ADDI:      next_state = S_EXEC_I;
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          default: begin
            next_state = S_EXC_REQ;
            exc_sel_d  = IORD_ILLEG;
          end
        endcase
      end

      S_EXEC_R: begin
        ALUSourceA  = SRCA_A;
        ALUSourceB  = SRCB_B;
        AluOutWrite = 1'b1;
        unique case (funct)
          FN_ADD:  AluOp = ALU_ADD;
          FN_SUB:  AluOp = ALU_SUB;
          FN_AND:  AluOp = ALU_AND;
          default: AluOp = ALU_PASSA;
        endcase
        if (ovf_trap_r) begin
          next_state = S_EXC_REQ;
          exc_sel_d  = IORD_OVF;
        end else begin
          next_state = S_WB_R;
        end
      end

      S_WB_R: begin
        RegWrite   = 1'b1;
        RegDst     = RDST_RD;
        MemToReg   = M2R_ALUOUT;
        next_state = S_FETCH;
      end

      S_EXEC_I: begin
        ALUSourceA  = SRCA_A;
        ALUSourceB  = SRCB_IMM;
        AluOp       = ALU_ADD;
        AluOutWrite = 1'b1;
        if (ovf_trap_i) begin
          next_state = S_EXC_REQ;
          exc_sel_d  = IORD_OVF;
        end else begin
          next_state = S_WB_I;
        end
      end

      S_WB_I: begin
        RegWrite   = 1'b1;
        RegDst     = RDST_RT;
        MemToReg   = M2R_ALUOUT;
        next_state = S_FETCH;
      end

      S_MEM_ADDR: begin
        ALUSourceA  = SRCA_A;
        ALUSourceB  = SRCB_IMM;
        AluOp       = ALU_ADD;
        AluOutWrite = 1'b1;
        next_state  = (opcode == OP_LW) ? S_LOAD_REQ : S_STORE;
      end

      S_LOAD_REQ: begin
        MEMRead    = 1'b1;
        IorD       = IORD_ALUOUT;
        next_state = S_LOAD_WAIT;
      end

      S_LOAD_WAIT: begin
        if (wait_done) begin
          MDRWrite   = 1'b1;
          next_state = S_LOAD_WB;
        end
      end

      S_LOAD_WB: begin
        RegWrite   = 1'b1;
        RegDst     = RDST_RT;
        MemToReg   = M2R_MDR;
        next_state = S_FETCH;
      end

      S_STORE: begin
        MEMWrite   = 1'b1;
        IorD       = IORD_ALUOUT;
        next_state = S_FETCH;
      end

      S_BRANCH: begin
        ALUSourceA       = SRCA_A;
        ALUSourceB       = SRCB_B;
        AluOp            = ALU_SUB;
        PCSource         = PCS_ALUOUT;
        PC_write_cond_eq = (opcode == OP_BEQ);
        PC_write_cond_ne = (opcode == OP_BNE);
        next_state       = S_FETCH;
      end

      S_JUMP: begin
        PC_write   = 1'b1;
        PCSource   = PCS_JUMP;
        next_state = S_FETCH;
      end

      // PC was already advanced in FETCH, so PC-4 recovers the faulting address.
      S_EXC_REQ: begin
        EPCWrite   = 1'b1;
        ALUSourceA = SRCA_PC;
        ALUSourceB = SRCB_FOUR;
        AluOp      = ALU_SUB;
        MEMRead    = 1'b1;
        IorD       = exc_sel;
        next_state = S_EXC_WAIT;
      end

      S_EXC_WAIT: begin
        if (wait_done) begin
          MDRWrite   = 1'b1;
          next_state = S_EXC_JUMP;
        end
      end

      S_EXC_JUMP: begin
        PC_write   = 1'b1;
        PCSource   = PCS_MDR;
        next_state = S_FETCH;
      end

      default: next_state = S_RESET;
    endcase
  end

  logic [2:0] wait_count_unused;
  assign wait_count_unused = wait_count;

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_multicycle_ctrl
// Brief  : Directed self-checking bench. Instance "a" uses MEM_WAIT=1,
//          instance "b" uses MEM_WAIT=3.
// Rev    : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- instance a ----------------
  logic       rst_a, ovf_a, zero_a;
  logic [5:0] op_a, fn_a;
  logic       pcw_a, pceq_a, pcne_a, mrd_a, mwr_a, irw_a, mdrw_a, rw_a, aw_a, bw_a, aow_a, epcw_a;
  logic [1:0] iord_a, rdst_a, m2r_a, srcb_a, pcs_a;
  logic       srca_a, rout_a;
  logic [2:0] aluop_a;
  logic [4:0] st_a;
  wire [11:0] strb_a = {pcw_a, pceq_a, pcne_a, mrd_a, mwr_a, irw_a, mdrw_a, rw_a, aw_a, bw_a, aow_a, epcw_a};
  wire [13:0] sel_a  = {iord_a, rdst_a, m2r_a, srca_a, srcb_a, pcs_a, aluop_a};

  multicycle_ctrl #(.MEM_WAIT(1), .OVF_EXC_EN(1'b1), .SP_INIT(227)) dut_a (
    .clk(clk), .reset(rst_a), .overflow(ovf_a), .zero(zero_a), .opcode(op_a), .funct(fn_a),
    .PC_write(pcw_a), .PC_write_cond_eq(pceq_a), .PC_write_cond_ne(pcne_a),
    .MEMRead(mrd_a), .MEMWrite(mwr_a), .IRWrite(irw_a), .MDRWrite(mdrw_a),
    .RegWrite(rw_a), .A_write(aw_a), .B_write(bw_a), .AluOutWrite(aow_a), .EPCWrite(epcw_a),
    .IorD(iord_a), .RegDst(rdst_a), .MemToReg(m2r_a), .ALUSourceA(srca_a), .ALUSourceB(srcb_a),
    .PCSource(pcs_a), .AluOp(aluop_a), .reset_out(rout_a), .state_dbg(st_a)
  );

  // ---------------- instance b ----------------
  logic       rst_b, ovf_b, zero_b;
  logic [5:0] op_b, fn_b;
  logic       pcw_b, pceq_b, pcne_b, mrd_b, mwr_b, irw_b, mdrw_b, rw_b, aw_b, bw_b, aow_b, epcw_b;
  logic [1:0] iord_b, rdst_b, m2r_b, srcb_b, pcs_b;
  logic       srca_b, rout_b;
  logic [2:0] aluop_b;
  logic [4:0] st_b;
  wire [11:0] strb_b = {pcw_b, pceq_b, pcne_b, mrd_b, mwr_b, irw_b, mdrw_b, rw_b, aw_b, bw_b, aow_b, epcw_b};
  wire [13:0] sel_b  = {iord_b, rdst_b, m2r_b, srca_b, srcb_b, pcs_b, aluop_b};

  multicycle_ctrl #(.MEM_WAIT(3), .OVF_EXC_EN(1'b1), .SP_INIT(227)) dut_b (
    .clk(clk), .reset(rst_b), .overflow(ovf_b), .zero(zero_b), .opcode(op_b), .funct(fn_b),
    .PC_write(pcw_b), .PC_write_cond_eq(pceq_b), .PC_write_cond_ne(pcne_b),
    .MEMRead(mrd_b), .MEMWrite(mwr_b), .IRWrite(irw_b), .MDRWrite(mdrw_b),
    .RegWrite(rw_b), .A_write(aw_b), .B_write(bw_b), .AluOutWrite(aow_b), .EPCWrite(epcw_b),
    .IorD(iord_b), .RegDst(rdst_b), .MemToReg(m2r_b), .ALUSourceA(srca_b), .ALUSourceB(srcb_b),
    .PCSource(pcs_b), .AluOp(aluop_b), .reset_out(rout_b), .state_dbg(st_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; ovf_a = 1'b0; zero_a = 1'b0; op_a = 6'h00; fn_a = 6'h00;
    rst_b = 1'b1; ovf_b = 1'b0; zero_b = 1'b0; op_b = 6'h00; fn_b = 6'h00;

    // ---- reset and SP init (a) ----
    tick(); tick();
    check("a_rst_state", st_a, S_RESET);
    check("a_rst_out", rout_a, 1);
    check("a_rst_strb", strb_a, 0);
    check("a_rst_sel", sel_a, 0);
    rst_a = 1'b0;
    tick();
    check("a_spinit_state", st_a, S_SP_INIT_WB);
    check("a_spinit_rout", rout_a, 0);
    check("a_spinit_strb", strb_a, 12'b0000_0001_0000);   // RegWrite only
    check("a_spinit_rdst", rdst_a, 2);
    check("a_spinit_m2r", m2r_a, 2);
    tick();
    check("a_fetch_state", st_a, S_FETCH);
    check("a_fetch_strb", strb_a, 12'b1001_0000_0000);    // PC_write, MEMRead
    check("a_fetch_sel", sel_a, {2'd0, 2'd0, 2'd0, 1'b0, 2'd1, 2'd0, 3'd1});

    // ---- add, no overflow: FETCH->FW->DECODE->EXEC_R->WB_R->FETCH ----
    op_a = 6'h00; fn_a = 6'h20;
    tick();
    check("a_add_fw_state", st_a, S_FETCH_WAIT);
    check("a_add_fw_irw", strb_a, 12'b0000_0100_0000);    // IRWrite (MEM_WAIT=1)
    tick();
    check("a_add_dec_state", st_a, S_DECODE);
    check("a_add_dec_strb", strb_a, 12'b0000_0000_1110); // A/B/AluOut write
    check("a_add_dec_srcb", srcb_a, 3);
    tick();
    check("a_add_exr_state", st_a, S_EXEC_R);
    check("a_add_exr_sel", sel_a, {2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0, 3'd1});
    tick();
    check("a_add_wbr_state", st_a, S_WB_R);
    check("a_add_wbr_strb", strb_a, 12'b0000_0001_0000);
    check("a_add_wbr_rdst", rdst_a, 1);
    tick();
    check("a_add_back_fetch", st_a, S_FETCH);

    // ---- addi with overflow -> exception vector 3 ----
    op_a = 6'h08; ovf_a = 1'b1;
    tick(); tick(); tick();
    check("a_addi_exi_state", st_a, S_EXEC_I);
    check("a_addi_exi_srcb", srcb_a, 2);
    tick();
    check("a_addi_exc_state", st_a, S_EXC_REQ);
    check("a_addi_exc_iord", iord_a, 3);
    check("a_addi_exc_strb", strb_a, 12'b0001_0000_0001);  // MEMRead, EPCWrite
    check("a_addi_exc_aluop", aluop_a, 2);
    tick();
    check("a_addi_excw_state", st_a, S_EXC_WAIT);
    check("a_addi_excw_strb", strb_a, 12'b0000_0010_0000); // MDRWrite
    tick();
    check("a_addi_excj_state", st_a, S_EXC_JUMP);
    check("a_addi_excj_pcs", pcs_a, 3);
    check("a_addi_excj_strb", strb_a, 12'b1000_0000_0000);
    tick();
    check("a_addi_back_fetch", st_a, S_FETCH);

    // ---- and with overflow flag high: no trap ----
    op_a = 6'h00; fn_a = 6'h24;
    tick(); tick(); tick();
    check("a_and_exr_aluop", aluop_a, 3);
    tick();
    check("a_and_wbr_state", st_a, S_WB_R);
    tick();
    ovf_a = 1'b0;

    // ---- sub with overflow -> trap ----
    fn_a = 6'h22; ovf_a = 1'b1;
    tick(); tick(); tick();
    check("a_sub_exr_aluop", aluop_a, 2);
    tick();
    check("a_sub_exc_state", st_a, S_EXC_REQ);
    check("a_sub_exc_iord", iord_a, 3);
    tick(); tick(); tick();
    ovf_a = 1'b0;

    // ---- illegal opcode 0x3F -> exception vector 2 ----
    op_a = 6'h3F;
    tick(); tick(); tick();
    check("a_ill_exc_state", st_a, S_EXC_REQ);
    check("a_ill_exc_iord", iord_a, 2);
    tick(); tick(); tick();
    check("a_ill_back_fetch", st_a, S_FETCH);

    // ---- bne ----
    op_a = 6'h05;
    tick(); tick(); tick();
    check("a_bne_state", st_a, S_BRANCH);
    check("a_bne_strb", strb_a, 12'b0010_0000_0000);
    check("a_bne_sel", sel_a, {2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd1, 3'd2});
    tick();

    // ---- beq ----
    op_a = 6'h04;
    tick(); tick(); tick();
    check("a_beq_strb", strb_a, 12'b0100_0000_0000);
    tick();

    // ---- jump ----
    op_a = 6'h02;
    tick(); tick(); tick();
    check("a_j_state", st_a, S_JUMP);
    check("a_j_pcs", pcs_a, 2);
    check("a_j_strb", strb_a, 12'b1000_0000_0000);
    tick();

    // ---- sw ----
    op_a = 6'h2B;
    tick(); tick(); tick();
    check("a_sw_addr_state", st_a, S_MEM_ADDR);
    check("a_sw_addr_sel", sel_a, {2'd0, 2'd0, 2'd0, 1'b1, 2'd2, 2'd0, 3'd1});
    tick();
    check("a_sw_store_state", st_a, S_STORE);
    check("a_sw_store_strb", strb_a, 12'b0000_1000_0000);
    check("a_sw_store_iord", iord_a, 1);
    tick();
    check("a_sw_back_fetch", st_a, S_FETCH);

    // ---- instance b: lw with MEM_WAIT=3 ----
    rst_b = 1'b0;
    tick();
    check("b_spinit_state", st_b, S_SP_INIT_WB);
    tick();
    check("b_fetch_state", st_b, S_FETCH);
    op_b = 6'h23;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("b_lw_fw%0d_state", i), st_b, S_FETCH_WAIT);
      check($sformatf("b_lw_fw%0d_irw", i), irw_b, (i == 2) ? 1 : 0);
    end
    tick();
    check("b_lw_dec_state", st_b, S_DECODE);
    tick();
    check("b_lw_addr_state", st_b, S_MEM_ADDR);
    tick();
    check("b_lw_req_state", st_b, S_LOAD_REQ);
    check("b_lw_req_strb", strb_b, 12'b0001_0000_0000);
    check("b_lw_req_iord", iord_b, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("b_lw_lw%0d_state", i), st_b, S_LOAD_WAIT);
      check($sformatf("b_lw_lw%0d_mdrw", i), mdrw_b, (i == 2) ? 1 : 0);
    end
    tick();
    check("b_lw_wb_state", st_b, S_LOAD_WB);
    check("b_lw_wb_strb", strb_b, 12'b0000_0001_0000);
    check("b_lw_wb_m2r", m2r_b, 1);
    check("b_lw_wb_rdst", rdst_b, 0);
    tick();
    check("b_lw_back_fetch", st_b, S_FETCH);

    // ---- second lw, reset asserted mid LOAD_WAIT ----
    tick(); tick(); tick(); tick(); tick(); tick();
    check("b_lw2_req_state", st_b, S_LOAD_REQ);
    tick(); tick();
    check("b_lw2_wait_state", st_b, S_LOAD_WAIT);
    rst_b = 1'b1;
    tick();
    check("b_midrst_state", st_b, S_RESET);
    check("b_midrst_strb", strb_b, 0);
    check("b_midrst_sel", sel_b, 0);
    check("b_midrst_rout", rout_b, 1);
    rst_b = 1'b0;
    tick(); tick();
    check("b_rerun_fetch", st_b, S_FETCH);
    // Wait counter must restart from zero: IRWrite only on the third FW cycle.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("b_refw%0d_state", i), st_b, S_FETCH_WAIT);
      check($sformatf("b_refw%0d_irw", i), irw_b, (i == 2) ? 1 : 0);
    end
    tick();
    check("b_re_dec_state", st_b, S_DECODE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_multicycle_ctrl
`default_nettype wire
